// File: rtl/pio_pkg.sv
// Shared register map, STATUS bit positions and timer state encoding for the
// pulse-output peripheral.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_PLEN   = 3'd3;
  localparam logic [2:0] ADDR_PULSE  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_IRQEN_BIT = 1;

  typedef enum logic {
    TMR_IDLE   = 1'b0,
    TMR_ACTIVE = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// One-shot pulse timer: loads a length on start and counts it down, flagging
// the final cycle with done_pulse.
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done_pulse
);

  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= TMR_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Starts are only honoured in IDLE, so a start in the expiry cycle is dropped.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_pulse = 1'b0;
    case (state_q)
      TMR_IDLE: begin
        if (start && (len != '0)) begin
          state_d = TMR_ACTIVE;
          count_d = len;
        end
      end
      TMR_ACTIVE: begin
        if (count_q == CNT_W'(1)) begin
          state_d    = TMR_IDLE;
          count_d    = '0;
          done_pulse = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = TMR_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign busy = (state_q == TMR_ACTIVE);

endmodule

// File: rtl/pio_pulse_out.sv
// Memory-mapped parallel output port with a timed inversion pulse on a
// selectable channel mask and a pulse-done interrupt.
module pio_pulse_out
  import pio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  // With 32 channels there is no spare bit above the mask, so busy takes bit 31.
  localparam int BUSY_BIT = (WIDTH < 32) ? WIDTH : 31;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic             done_q, done_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic             wr;
  logic [WIDTH-1:0] wr_bits;
  logic [CNT_W-1:0] wr_len;
  logic             start;
  logic             busy;
  logic             done_pulse;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wr_bits      = writedata[WIDTH-1:0];
  assign wr_len       = writedata[CNT_W-1:0];
  assign unused_wdata = ^writedata;

  assign start = wr && (address == ADDR_PULSE) && !busy &&
                 (wr_bits != '0) && (plen_q != '0);

  pio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .len        (plen_q),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always_comb begin
    data_d   = data_q;
    plen_d   = plen_q;
    mask_d   = mask_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d = wr_bits;
        ADDR_SET:    data_d = data_q | wr_bits;
        ADDR_CLEAR:  data_d = data_q & ~wr_bits;
        ADDR_PLEN:   plen_d = wr_len;
        ADDR_STATUS: begin
          if (writedata[STAT_DONE_BIT]) done_d = 1'b0;
          irq_en_d = writedata[STAT_IRQEN_BIT];
        end
        default: ;
      endcase
    end
    if (start) begin
      mask_d = wr_bits;
    end else if (done_pulse) begin
      mask_d = '0;
    end
    // Expiry overrides a coincident done-clear.
    if (done_pulse) done_d = 1'b1;
    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= RESET_VAL;
      plen_q   <= '0;
      mask_q   <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      plen_q   <= plen_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign out_port = data_q ^ (busy ? mask_q : '0);
  assign irq      = irq_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
      ADDR_PLEN:   readdata[CNT_W-1:0] = plen_q;
      ADDR_PULSE: begin
        readdata[WIDTH-1:0] = mask_q;
        readdata[BUSY_BIT]  = busy;
      end
      ADDR_STATUS: begin
        readdata[STAT_DONE_BIT]  = done_q;
        readdata[STAT_IRQEN_BIT] = irq_en_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pio_pulse_out.sv
// Scoreboard bench for pio_pulse_out: directed bus writes queue expected
// observations, a negedge monitor pops and compares them.
module tb_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  pio_pulse_out #(
    .WIDTH     (8),
    .CNT_W     (16),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = {24'd0, out_port};
        1:       act = {31'd0, irq};
        default: act = readdata;
      endcase
      tests++;
      if (e.cyc != cycle || act !== e.val) begin
        fails++;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.val, cycle);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cycle;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_out(input logic [7:0] v, input string name);
    push(0, {24'd0, v}, name);
  endtask

  task automatic exp_irq(input logic v, input string name);
    push(1, {31'd0, v}, name);
  endtask

  task automatic exp_rd(input logic [2:0] a, input logic [31:0] v, input string name);
    address = a;
    push(2, v, name);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic set_reset(input logic v);
    @(negedge clk);
    #1;
    reset_n = v;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values, including readback while reset is still asserted
    tick();
    exp_out(8'hA5, "rst_out");
    exp_irq(1'b0, "rst_irq");
    exp_rd(3'd0, 32'hA5, "rst_rd_data");
    tick();
    exp_rd(3'd3, 32'h0, "rst_rd_plen");
    tick();
    exp_rd(3'd4, 32'h0, "rst_rd_pulse");
    tick();
    exp_rd(3'd5, 32'h0, "rst_rd_status");
    set_reset(1'b1);
    tick();

    // DATA / SET / CLEAR
    bus_write(3'd0, 32'hFFFF_FF0F);
    exp_out(8'h0F, "data_wr");
    bus_write(3'd1, 32'h0000_00F0);
    exp_out(8'hFF, "set_wr");
    bus_write(3'd2, 32'h0000_0003);
    exp_out(8'hFC, "clear_wr");
    exp_rd(3'd0, 32'hFC, "rd_data");
    tick();
    exp_rd(3'd1, 32'h0, "rd_set_wo");
    bus_write(3'd6, 32'hFF);
    exp_out(8'hFC, "unmapped_wr");
    exp_rd(3'd6, 32'h0, "rd_unmapped");

    // Basic 5-cycle pulse
    bus_write(3'd3, 32'h0001_0005);
    exp_rd(3'd3, 32'h5, "rd_plen");
    bus_write(3'd0, 32'h00);
    exp_out(8'h00, "data_zero");
    bus_write(3'd4, 32'h81);
    for (int i = 0; i < 5; i++) begin
      exp_out(8'h81, "pulse5_out");
      exp_rd(3'd4, 32'h181, "pulse5_busy");
      tick();
    end
    exp_out(8'h00, "pulse5_end");
    exp_irq(1'b0, "pulse5_irq_masked");
    exp_rd(3'd5, 32'h1, "pulse5_done");
    tick();
    exp_rd(3'd4, 32'h0, "pulse5_idle");
    bus_write(3'd5, 32'h1);
    exp_rd(3'd5, 32'h0, "done_clr");

    // Ignored pulse starts: zero length, zero mask
    bus_write(3'd3, 32'h0);
    bus_write(3'd4, 32'hFF);
    exp_out(8'h00, "plen0_out");
    exp_rd(3'd4, 32'h0, "plen0_busy");
    tick();
    exp_rd(3'd5, 32'h0, "plen0_nodone");
    bus_write(3'd3, 32'h4);
    bus_write(3'd4, 32'h00);
    exp_out(8'h00, "mask0_out");
    exp_rd(3'd4, 32'h0, "mask0_busy");

    // Mid-pulse PULSE and DATA writes
    bus_write(3'd3, 32'h3);
    bus_write(3'd4, 32'h81);
    exp_out(8'h81, "mid_c1");
    bus_write(3'd4, 32'hFF);
    exp_out(8'h81, "mid_c2");
    exp_rd(3'd4, 32'h181, "mid_mask_kept");
    bus_write(3'd0, 32'h10);
    exp_out(8'h91, "mid_c3");
    tick();
    exp_out(8'h10, "mid_end");
    exp_rd(3'd4, 32'h0, "mid_idle");
    bus_write(3'd5, 32'h1);

    // PLEN write during a pulse, PULSE write on the expiry edge
    bus_write(3'd3, 32'h2);
    bus_write(3'd4, 32'h01);
    exp_out(8'h11, "exp_c1");
    bus_write(3'd3, 32'h1);
    exp_out(8'h11, "exp_c2");
    exp_rd(3'd3, 32'h1, "plen_mid");
    bus_write(3'd4, 32'h02);
    exp_out(8'h10, "exp_end");
    exp_rd(3'd4, 32'h0, "exp_pulse_ignored");
    tick();
    exp_out(8'h10, "exp_after");
    exp_rd(3'd5, 32'h1, "exp_done");

    // Interrupt enable, clear, and set-wins-over-clear
    bus_write(3'd5, 32'h3);
    exp_rd(3'd5, 32'h2, "irqen_set");
    exp_irq(1'b0, "irq_off");
    bus_write(3'd4, 32'h01);
    exp_out(8'h11, "len1_out");
    exp_irq(1'b0, "len1_irq_pre");
    tick();
    exp_out(8'h10, "len1_end");
    exp_irq(1'b1, "irq_on");
    exp_rd(3'd5, 32'h3, "irq_status");
    bus_write(3'd5, 32'h3);
    exp_irq(1'b0, "irq_cleared");
    exp_rd(3'd5, 32'h2, "irq_clr_status");
    bus_write(3'd4, 32'h01);
    exp_out(8'h11, "coinc_out");
    bus_write(3'd5, 32'h3);
    exp_irq(1'b1, "coinc_irq");
    exp_rd(3'd5, 32'h3, "coinc_done");
    exp_out(8'h10, "coinc_end");

    // Reset aborts a pulse in progress
    bus_write(3'd5, 32'h3);
    bus_write(3'd3, 32'hA);
    bus_write(3'd4, 32'hFF);
    exp_out(8'hEF, "abort_c1");
    tick();
    exp_out(8'hEF, "abort_c2");
    set_reset(1'b0);
    tick();
    exp_out(8'hA5, "abort_out");
    exp_rd(3'd4, 32'h0, "abort_busy");
    exp_irq(1'b0, "abort_irq");
    tick();
    exp_rd(3'd5, 32'h0, "abort_status");
    set_reset(1'b1);
    tick();
    exp_out(8'hA5, "abort_post");
    exp_rd(3'd4, 32'h0, "abort_post_busy");

    tick();
    tick();
    tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
